// File: rtl/flag_ctx_unit_pkg.sv
// rtl/flag_ctx_unit_pkg.sv - opcode/condition encodings and flag-writer decode shared by flag_ctx_unit
package flag_ctx_unit_pkg;

  // Opcode field is issue_instr[15:12]; ADD owns 4'h0 so the all-zero word decodes as ADD-NOP.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;

  typedef enum logic [2:0] {
    COND_EQUAL            = 3'd0,
    COND_NOT_EQUAL        = 3'd1,
    COND_LESS             = 3'd2,
    COND_GREATER          = 3'd3,
    COND_GREATER_OR_EQUAL = 3'd4,
    COND_LESS_OR_EQUAL    = 3'd5,
    COND_OVERFLOW         = 3'd6,
    COND_TRUE             = 3'd7
  } cond_e;

  function automatic logic is_flag_writer(input logic [15:0] instr);
    logic [3:0] op;
    op = instr[15:12];
    case (op)
      OP_SUB, OP_NAND, OP_XOR, OP_INC: is_flag_writer = 1'b1;
      OP_ADD:                          is_flag_writer = (instr != 16'h0000);
      default:                         is_flag_writer = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flag_ctx_unit_cond_eval.sv
// rtl/flag_ctx_unit_cond_eval.sv - combinational {z,v,n} x condition -> taken evaluator
module flag_cond_eval
  import flag_ctx_unit_pkg::*;
(
  input  logic [2:0] zvn,
  input  logic [2:0] cond,
  output logic       taken
);

  logic z, v, n;
  assign {z, v, n} = zvn;

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQUAL:            taken = z;
      COND_NOT_EQUAL:        taken = ~z;
      COND_LESS:             taken = n & ~v;
      COND_GREATER:          taken = ~z & ~n & ~v;
      COND_GREATER_OR_EQUAL: taken = ~n & ~v;
      COND_LESS_OR_EQUAL:    taken = (n & ~v) | z;
      COND_OVERFLOW:         taken = v;
      COND_TRUE:             taken = 1'b1;
      default:               taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctx_unit.sv
// rtl/flag_ctx_unit.sv - per-context Z/V/N flags, pending-writer tracking, branch stall and bypass
module flag_ctx_unit
  import flag_ctx_unit_pkg::*;
#(
  parameter int NUM_CTX  = 2,
  parameter int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int PEND_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [CTX_W-1:0]     issue_ctx,
  input  logic [15:0]          issue_instr,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [CTX_W-1:0]     wb_ctx,
  input  logic                 wb_sets_flags,
  input  logic                 wb_z,
  input  logic                 wb_v,
  input  logic                 wb_n,
  input  logic                 br_valid,
  input  logic [CTX_W-1:0]     br_ctx,
  input  logic [2:0]           br_cond,
  output logic                 br_stall,
  output logic                 br_resp_valid,
  output logic                 br_taken,
  output logic [3*NUM_CTX-1:0] flags_out,
  input  logic                 flush,
  input  logic [CTX_W-1:0]     flush_ctx
);

  localparam int PW = $clog2(PEND_MAX + 1);

  logic [PW-1:0] pend [NUM_CTX];
  logic [2:0]    flg  [NUM_CTX];

  logic          wb_fire;
  logic          issue_fire;
  logic [2:0]    wb_flags;
  logic [PW-1:0] iss_pend;
  logic [PW-1:0] br_pend;
  logic [2:0]    br_stored;
  logic          bypass;
  logic [2:0]    eval_flags;
  logic          eval_taken;

  assign wb_fire    = wb_valid && wb_sets_flags;
  assign wb_flags   = {wb_z, wb_v, wb_n};
  assign issue_fire = issue_valid && issue_ready && is_flag_writer(issue_instr);

  // Context-indexed reads as explicit muxes so out-of-range indices read as zero.
  always_comb begin
    iss_pend  = '0;
    br_pend   = '0;
    br_stored = '0;
    for (int k = 0; k < NUM_CTX; k++) begin
      if (issue_ctx == CTX_W'(k)) iss_pend = pend[k];
      if (br_ctx == CTX_W'(k)) begin
        br_pend   = pend[k];
        br_stored = flg[k];
      end
    end
  end

  assign issue_ready = (iss_pend != PW'(PEND_MAX));

  // The last outstanding writer landing this cycle is the only one whose flags can be forwarded.
  assign bypass     = wb_fire && (wb_ctx == br_ctx) && (br_pend == PW'(1));
  assign br_stall   = br_valid && !((br_pend == '0) || bypass);
  assign eval_flags = bypass ? wb_flags : br_stored;

  flag_cond_eval u_cond_eval (
    .zvn   (eval_flags),
    .cond  (br_cond),
    .taken (eval_taken)
  );

  for (genvar k = 0; k < NUM_CTX; k++) begin : g_ctx
    logic inc, dec;
    assign inc = issue_fire && (issue_ctx == CTX_W'(k));
    assign dec = wb_fire && (wb_ctx == CTX_W'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend[k] <= '0;
      end else if (flush && (flush_ctx == CTX_W'(k))) begin
        pend[k] <= '0;
      end else if (inc && !dec) begin
        pend[k] <= pend[k] + PW'(1);
      end else if (dec && !inc && (pend[k] != '0)) begin
        pend[k] <= pend[k] - PW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flg[k] <= '0;
      end else if (dec) begin
        flg[k] <= wb_flags;
      end
    end

    assign flags_out[3*k +: 3] = flg[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_resp_valid <= 1'b0;
      br_taken      <= 1'b0;
    end else begin
      br_resp_valid <= br_valid && !br_stall;
      if (br_valid && !br_stall) br_taken <= eval_taken;
    end
  end

endmodule
